// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes {g,f,e,d,c,b,a},
// the hex decoder function, and the scan slot phase type.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {PH_BLANK, PH_SHOW} scan_phase_e;

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    hex2seg = SEG_OFF;
    case (nibble)
      4'h0: hex2seg = SEG_0;
      4'h1: hex2seg = SEG_1;
      4'h2: hex2seg = SEG_2;
      4'h3: hex2seg = SEG_3;
      4'h4: hex2seg = SEG_4;
      4'h5: hex2seg = SEG_5;
      4'h6: hex2seg = SEG_6;
      4'h7: hex2seg = SEG_7;
      4'h8: hex2seg = SEG_8;
      4'h9: hex2seg = SEG_9;
      4'hA: hex2seg = SEG_A;
      4'hB: hex2seg = SEG_B;
      4'hC: hex2seg = SEG_C;
      4'hD: hex2seg = SEG_D;
      4'hE: hex2seg = SEG_E;
      4'hF: hex2seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble -> active-low 7-segment decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: one digit per slot, dead-time
// at slot start, frame-coherent input snapshot, optional leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int NUM_DIG   = 8,
  parameter int BLANK_CYC = 500
) (
  input  logic                   CLK_50,
  input  logic                   rst_n,
  input  logic [4*NUM_DIG-1:0]   data,
  input  logic [NUM_DIG-1:0]     dp,
  input  logic [NUM_DIG-1:0]     dig_en,
  input  logic                   lz_sup,
  output logic [NUM_DIG-1:0]     SEL,
  output logic [7:0]             DIG
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIG - 1);
  localparam scan_phase_e      PH_RST    = (BLANK_CYC > 0) ? PH_BLANK : PH_SHOW;

  if (CLK_HZ % SCAN_HZ != 0) begin : g_err_div
    $error("seg7_scan_mux: CLK_HZ must be a multiple of SCAN_HZ");
  end
  if (BLANK_CYC >= TICK_DIV) begin : g_err_blank
    $error("seg7_scan_mux: BLANK_CYC must be below CLK_HZ/SCAN_HZ");
  end
  if (NUM_DIG < 1 || NUM_DIG > 8) begin : g_err_ndig
    $error("seg7_scan_mux: NUM_DIG must be 1..8");
  end

  logic [CNT_W-1:0]          pre_cnt, pre_cnt_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  scan_phase_e               phase, phase_nxt;
  logic                      frame_start;

  logic [NUM_DIG-1:0][3:0]   snap_data;
  logic [NUM_DIG-1:0]        snap_dp, snap_dig_en;
  logic                      snap_lz_sup;

  logic [NUM_DIG-1:0]        lz_blank;
  logic                      zero_run;
  logic [3:0]                cur_nib;
  logic [6:0]                cur_seg;
  logic [NUM_DIG-1:0]        sel_nxt;
  logic [7:0]                dig_nxt;

  // Phase is registered alongside pre_cnt so it always equals (pre_cnt < BLANK_CYC).
  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      idx     <= '0;
      phase   <= PH_RST;
    end else begin
      pre_cnt <= pre_cnt_nxt;
      idx     <= idx_nxt;
      phase   <= phase_nxt;
    end
  end

  always_comb begin
    pre_cnt_nxt = (pre_cnt == CNT_LAST) ? '0 : pre_cnt + 1'b1;
    idx_nxt     = idx;
    if (pre_cnt == CNT_LAST)
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    phase_nxt   = (pre_cnt_nxt < BLANK_LIM) ? PH_BLANK : PH_SHOW;
  end

  assign frame_start = (pre_cnt == '0) && (idx == '0);

  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) begin
      snap_data   <= '0;
      snap_dp     <= '0;
      snap_dig_en <= '0;
      snap_lz_sup <= 1'b0;
    end else if (frame_start) begin
      snap_data   <= data;
      snap_dp     <= dp;
      snap_dig_en <= dig_en;
      snap_lz_sup <= lz_sup;
    end
  end

  // Walk from the most significant digit down; a digit is blanked while all
  // nibbles at and above it are zero. Digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      zero_run = zero_run & (snap_data[i] == 4'h0);
      if (i != 0) lz_blank[i] = snap_lz_sup & zero_run;
    end
  end

  assign cur_nib = snap_data[idx];

  seg7_hex_dec u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_comb begin
    sel_nxt = '1;
    dig_nxt = 8'hFF;
    if (phase == PH_SHOW && snap_dig_en[idx]) begin
      sel_nxt[idx] = 1'b0;
      dig_nxt      = {~snap_dp[idx], lz_blank[idx] ? SEG_OFF : cur_seg};
    end
  end

  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) begin
      SEL <= '1;
      DIG <= 8'hFF;
    end else begin
      SEL <= sel_nxt;
      DIG <= dig_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: 4 digits, 10-cycle slots, 2 dead cycles.
module tb_seg7_scan_mux;

  logic        CLK_50 = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] data   = 16'h1234;
  logic [3:0]  dp     = 4'h0;
  logic [3:0]  dig_en = 4'hF;
  logic        lz_sup = 1'b0;
  logic [3:0]  SEL;
  logic [7:0]  DIG;

  int n_cmp = 0;
  int n_err = 0;

  seg7_scan_mux #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .NUM_DIG   (4),
    .BLANK_CYC (2)
  ) dut (
    .CLK_50 (CLK_50),
    .rst_n  (rst_n),
    .data   (data),
    .dp     (dp),
    .dig_en (dig_en),
    .lz_sup (lz_sup),
    .SEL    (SEL),
    .DIG    (DIG)
  );

  always #5 CLK_50 = ~CLK_50;

  task automatic chk(input string tag, input logic [3:0] esel, input logic [7:0] edig);
    n_cmp++;
    assert ({SEL, DIG} === {esel, edig}) else begin
      n_err++;
      $error("FAIL %s: got SEL=%b DIG=%b, want SEL=%b DIG=%b", tag, SEL, DIG, esel, edig);
    end
  endtask

  // Cycles c of a slot, counted from the frame/slot boundary edge; c<2 is dead time.
  task automatic check_range(input string tag, input logic [3:0] esel, input logic [7:0] edig,
                             input int from, input int to);
    for (int c = from; c <= to; c++) begin
      @(posedge CLK_50);
      @(negedge CLK_50);
      if (c < 2) chk(tag, 4'hF, 8'hFF);
      else       chk(tag, esel, edig);
    end
  endtask

  task automatic check_slot(input string tag, input logic [3:0] esel, input logic [7:0] edig);
    check_range(tag, esel, edig, 0, 9);
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_hold", 4'hF, 8'hFF);
    @(negedge CLK_50);
    chk("reset_hold2", 4'hF, 8'hFF);
    rst_n = 1'b1;

    // 1234, no suppression: two full frames
    for (int f = 0; f < 2; f++) begin
      check_slot("f1234_d0", 4'b1110, 8'b1_0011001);
      check_slot("f1234_d1", 4'b1101, 8'b1_0110000);
      check_slot("f1234_d2", 4'b1011, 8'b1_0100100);
      check_slot("f1234_d3", 4'b0111, 8'b1_1111001);
    end

    // Leading-zero suppression of 0007
    data = 16'h0007; lz_sup = 1'b1;
    check_slot("lz7_d0", 4'b1110, 8'b1_1111000);
    check_slot("lz7_d1", 4'b1101, 8'hFF);
    check_slot("lz7_d2", 4'b1011, 8'hFF);
    check_slot("lz7_d3", 4'b0111, 8'hFF);

    // All zero: digit 0 is never suppressed
    data = 16'h0000;
    check_slot("lz0_d0", 4'b1110, 8'b1_1000000);
    check_slot("lz0_d1", 4'b1101, 8'hFF);
    check_slot("lz0_d2", 4'b1011, 8'hFF);
    check_slot("lz0_d3", 4'b0111, 8'hFF);

    // dp on a suppressed digit still lights
    dp = 4'b0100;
    check_slot("lzdp_d0", 4'b1110, 8'b1_1000000);
    check_slot("lzdp_d1", 4'b1101, 8'hFF);
    check_slot("lzdp_d2", 4'b1011, 8'b0_1111111);
    check_slot("lzdp_d3", 4'b0111, 8'hFF);

    // Disabled digits stay deselected; frame period unchanged
    dp = 4'h0; lz_sup = 1'b0; data = 16'h1234; dig_en = 4'b0101;
    check_slot("en_d0", 4'b1110, 8'b1_0011001);
    check_slot("en_d1", 4'b1111, 8'hFF);
    check_slot("en_d2", 4'b1011, 8'b1_0100100);
    check_slot("en_d3", 4'b1111, 8'hFF);

    // Mid-frame data change is held off until the next frame
    dig_en = 4'hF;
    check_slot("tear_d0", 4'b1110, 8'b1_0011001);
    check_slot("tear_d1", 4'b1101, 8'b1_0110000);
    check_range("tear_d2", 4'b1011, 8'b1_0100100, 0, 4);
    data = 16'hABCD;
    check_range("tear_d2b", 4'b1011, 8'b1_0100100, 5, 9);
    check_slot("tear_d3", 4'b0111, 8'b1_1111001);
    check_slot("abcd_d0", 4'b1110, 8'b1_0100001);
    check_slot("abcd_d1", 4'b1101, 8'b1_1000110);
    check_slot("abcd_d2", 4'b1011, 8'b1_0000011);
    check_slot("abcd_d3", 4'b0111, 8'b1_0001000);

    // Asynchronous reset during SHOW of slot 2
    check_slot("rst_d0", 4'b1110, 8'b1_0100001);
    check_slot("rst_d1", 4'b1101, 8'b1_1000110);
    check_range("rst_d2", 4'b1011, 8'b1_0000011, 0, 4);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 4'hF, 8'hFF);
    @(negedge CLK_50);
    chk("rst_held", 4'hF, 8'hFF);
    rst_n = 1'b1;
    check_slot("rst_restart_d0", 4'b1110, 8'b1_0100001);
    check_slot("rst_restart_d1", 4'b1101, 8'b1_1000110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
